// File: rtl/multi_stage_synchronizer.sv
// Brings a bus of independent control/status bits into the clk domain through a
// configurable flop chain, then applies a per-bit stability filter and edge detect.
module multi_stage_synchronizer #(
  parameter int               WIDTH       = 1,
  parameter int               STAGES      = 2,
  parameter int               FILTER_LEN  = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed
);

  localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  if (STAGES < 2) begin : g_stages_chk
    $error("multi_stage_synchronizer: STAGES must be at least 2");
  end
  if (FILTER_LEN < 1) begin : g_filter_chk
    $error("multi_stage_synchronizer: FILTER_LEN must be at least 1");
  end
  if (WIDTH < 1) begin : g_width_chk
    $error("multi_stage_synchronizer: WIDTH must be at least 1");
  end

  (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] sync_r [STAGES];

  logic [WIDTH-1:0] sync_last_s;
  logic [CNT_W-1:0] cnt_r     [WIDTH];
  logic [CNT_W-1:0] cnt_nxt_s [WIDTH];
  logic [WIDTH-1:0] out_r;
  logic [WIDTH-1:0] out_nxt_s;
  logic [WIDTH-1:0] rise_r;
  logic [WIDTH-1:0] fall_r;
  logic [WIDTH-1:0] rise_nxt_s;
  logic [WIDTH-1:0] fall_nxt_s;
  logic             changed_r;

  assign sync_last_s = sync_r[STAGES-1];

  // Synchronizer chain: pure flop-to-flop, nothing between stages.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        sync_r[k] <= RESET_VALUE;
      end
    end else begin
      sync_r[0] <= in;
      for (int k = 1; k < STAGES; k++) begin
        sync_r[k] <= sync_r[k-1];
      end
    end
  end

  // Filter: out follows the synchronized bit only after FILTER_LEN consecutive differing cycles.
  always_comb begin
    out_nxt_s = out_r;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_nxt_s[i] = CNT_W'(0);
      if (sync_last_s[i] == out_r[i]) begin
        cnt_nxt_s[i] = CNT_W'(0);
      end else if (cnt_r[i] == CNT_W'(FILTER_LEN - 1)) begin
        out_nxt_s[i] = sync_last_s[i];
        cnt_nxt_s[i] = CNT_W'(0);
      end else begin
        cnt_nxt_s[i] = cnt_r[i] + CNT_W'(1);
      end
    end
  end

  assign rise_nxt_s = out_nxt_s & ~out_r;
  assign fall_nxt_s = ~out_nxt_s & out_r;

  // Filter state plus edge pulses, all registered at the edge that updates out.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_r     <= RESET_VALUE;
      rise_r    <= {WIDTH{1'b0}};
      fall_r    <= {WIDTH{1'b0}};
      changed_r <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_r[i] <= CNT_W'(0);
      end
    end else begin
      out_r     <= out_nxt_s;
      rise_r    <= rise_nxt_s;
      fall_r    <= fall_nxt_s;
      changed_r <= |(rise_nxt_s | fall_nxt_s);
      for (int i = 0; i < WIDTH; i++) begin
        cnt_r[i] <= cnt_nxt_s[i];
      end
    end
  end

  assign out     = out_r;
  assign rise    = rise_r;
  assign fall    = fall_r;
  assign changed = changed_r;

endmodule

// File: tb/tb_multi_stage_synchronizer.sv
// Directed bench for multi_stage_synchronizer: several parameterisations driven
// synchronously, with hand-computed expected outputs.
module tb_multi_stage_synchronizer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic rst_n, rst_f;
  logic [3:0] in_a; logic [3:0] out_a, rise_a, fall_a; logic ch_a;
  logic [0:0] in_b; logic [0:0] out_b, rise_b, fall_b; logic ch_b;
  logic [0:0] in_c; logic [0:0] out_c, rise_c, fall_c; logic ch_c;
  logic [1:0] in_d; logic [1:0] out_d, rise_d, fall_d; logic ch_d;
  logic [0:0] in_e; logic [0:0] out_e, rise_e, fall_e; logic ch_e;
  logic [0:0] in_f; logic [0:0] out_f, rise_f, fall_f; logic ch_f;

  multi_stage_synchronizer #(.WIDTH(4), .STAGES(2), .FILTER_LEN(1), .RESET_VALUE(4'h0)) u_a (
    .clk(clk), .rst_n(rst_n), .in(in_a), .out(out_a), .rise(rise_a), .fall(fall_a), .changed(ch_a));
  multi_stage_synchronizer #(.WIDTH(1), .STAGES(3), .FILTER_LEN(1), .RESET_VALUE(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .in(in_b), .out(out_b), .rise(rise_b), .fall(fall_b), .changed(ch_b));
  multi_stage_synchronizer #(.WIDTH(1), .STAGES(2), .FILTER_LEN(3), .RESET_VALUE(1'b0)) u_c (
    .clk(clk), .rst_n(rst_n), .in(in_c), .out(out_c), .rise(rise_c), .fall(fall_c), .changed(ch_c));
  multi_stage_synchronizer #(.WIDTH(2), .STAGES(2), .FILTER_LEN(1), .RESET_VALUE(2'b00)) u_d (
    .clk(clk), .rst_n(rst_n), .in(in_d), .out(out_d), .rise(rise_d), .fall(fall_d), .changed(ch_d));
  multi_stage_synchronizer #(.WIDTH(1), .STAGES(2), .FILTER_LEN(1), .RESET_VALUE(1'b1)) u_e (
    .clk(clk), .rst_n(rst_n), .in(in_e), .out(out_e), .rise(rise_e), .fall(fall_e), .changed(ch_e));
  multi_stage_synchronizer #(.WIDTH(1), .STAGES(2), .FILTER_LEN(4), .RESET_VALUE(1'b0)) u_f (
    .clk(clk), .rst_n(rst_f), .in(in_f), .out(out_f), .rise(rise_f), .fall(fall_f), .changed(ch_f));

  typedef struct {
    logic [3:0] in;
    logic [3:0] out;
    logic [3:0] rise;
    logic [3:0] fall;
    logic       changed;
  } vec_t;

  vec_t tbl [14];

  // Advance one clock and settle just past the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Packs {out, rise, fall, changed} of a 1-bit instance for compact checks.
  function automatic logic [3:0] pk(input logic o, input logic r, input logic f, input logic c);
    return {o, r, f, c};
  endfunction

  initial begin
    // Row j: in driven after edge j; outputs expected after edge j (in from row j-3).
    tbl[0]  = '{4'h0, 4'h0, 4'h0, 4'h0, 1'b0};
    tbl[1]  = '{4'hA, 4'h0, 4'h0, 4'h0, 1'b0};
    tbl[2]  = '{4'hA, 4'h0, 4'h0, 4'h0, 1'b0};
    tbl[3]  = '{4'hA, 4'h0, 4'h0, 4'h0, 1'b0};
    tbl[4]  = '{4'hA, 4'hA, 4'hA, 4'h0, 1'b1};
    tbl[5]  = '{4'h5, 4'hA, 4'h0, 4'h0, 1'b0};
    tbl[6]  = '{4'h5, 4'hA, 4'h0, 4'h0, 1'b0};
    tbl[7]  = '{4'hF, 4'hA, 4'h0, 4'h0, 1'b0};
    tbl[8]  = '{4'hF, 4'h5, 4'h5, 4'hA, 1'b1};
    tbl[9]  = '{4'h0, 4'h5, 4'h0, 4'h0, 1'b0};
    tbl[10] = '{4'h0, 4'hF, 4'hA, 4'h0, 1'b1};
    tbl[11] = '{4'h0, 4'hF, 4'h0, 4'h0, 1'b0};
    tbl[12] = '{4'h0, 4'h0, 4'h0, 4'hF, 1'b1};
    tbl[13] = '{4'h0, 4'h0, 4'h0, 4'h0, 1'b0};

    rst_n = 1'b0; rst_f = 1'b0;
    in_a = 4'h0; in_b = 1'b0; in_c = 1'b0; in_d = 2'b00; in_e = 1'b1; in_f = 1'b0;
    repeat (3) tick();
    chk("rst A", {out_a, rise_a, fall_a, 3'b000, ch_a}, 32'h0);
    chk("rst C", pk(out_c, rise_c, fall_c, ch_c), 32'h0);
    chk("rst E out", pk(out_e, rise_e, fall_e, ch_e), 32'h8);
    rst_n = 1'b1; rst_f = 1'b1;

    // Instance A: table-driven 4-bit sequence with mixed rise/fall.
    for (int i = 0; i < 14; i++) begin
      tick();
      chk($sformatf("A%0d out", i), out_a, tbl[i].out);
      chk($sformatf("A%0d rise", i), rise_a, tbl[i].rise);
      chk($sformatf("A%0d fall", i), fall_a, tbl[i].fall);
      chk($sformatf("A%0d changed", i), ch_a, tbl[i].changed);
      in_a = tbl[i].in;
    end

    // Instance D: 01 -> 10 in one step gives simultaneous rise and fall.
    in_d = 2'b01;
    repeat (3) tick();
    chk("D first", {out_d, rise_d, fall_d, ch_d}, {2'b01, 2'b01, 2'b00, 1'b1});
    in_d = 2'b10;
    tick(); tick();
    chk("D hold", {out_d, rise_d, fall_d, ch_d}, {2'b01, 2'b00, 2'b00, 1'b0});
    tick();
    chk("D swap", {out_d, rise_d, fall_d, ch_d}, {2'b10, 2'b10, 2'b01, 1'b1});
    tick();
    chk("D after", {out_d, rise_d, fall_d, ch_d}, {2'b10, 2'b00, 2'b00, 1'b0});

    // Instance B: three stages add one edge of latency.
    in_b = 1'b1;
    repeat (3) tick();
    chk("B pre-rise", pk(out_b, rise_b, fall_b, ch_b), 32'h0);
    tick();
    chk("B rise", pk(out_b, rise_b, fall_b, ch_b), 32'hD);
    tick();
    chk("B high", pk(out_b, rise_b, fall_b, ch_b), 32'h8);
    in_b = 1'b0;
    repeat (3) tick();
    chk("B pre-fall", pk(out_b, rise_b, fall_b, ch_b), 32'h8);
    tick();
    chk("B fall", pk(out_b, rise_b, fall_b, ch_b), 32'h3);
    tick();
    chk("B low", pk(out_b, rise_b, fall_b, ch_b), 32'h0);

    // Instance C: 1- and 2-cycle pulses are rejected by the 3-cycle filter.
    in_c = 1'b1;
    tick();
    in_c = 1'b0;
    for (int k = 0; k < 7; k++) begin
      tick();
      chk($sformatf("C p1 k%0d", k), pk(out_c, rise_c, fall_c, ch_c), 32'h0);
    end
    in_c = 1'b1;
    tick(); tick();
    in_c = 1'b0;
    for (int k = 0; k < 7; k++) begin
      tick();
      chk($sformatf("C p2 k%0d", k), pk(out_c, rise_c, fall_c, ch_c), 32'h0);
    end
    in_c = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      logic eo, er, ef;
      tick();
      eo = (k >= 5) && (k <= 7);
      er = (k == 5);
      ef = (k == 8);
      chk($sformatf("C p3 k%0d", k), pk(out_c, rise_c, fall_c, ch_c), pk(eo, er, ef, er | ef));
      if (k == 3) in_c = 1'b0;
    end

    // Instance E: reset value 1 with in held high, then a single fall.
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("E hold k%0d", k), pk(out_e, rise_e, fall_e, ch_e), 32'h8);
    end
    in_e = 1'b0;
    tick(); tick();
    chk("E pre-fall", pk(out_e, rise_e, fall_e, ch_e), 32'h8);
    tick();
    chk("E fall", pk(out_e, rise_e, fall_e, ch_e), 32'h3);
    tick();
    chk("E low", pk(out_e, rise_e, fall_e, ch_e), 32'h0);

    // Instance F: reset mid-count, then a full restart of the filter.
    in_f = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("F count k%0d", k), pk(out_f, rise_f, fall_f, ch_f), 32'h0);
    end
    rst_f = 1'b0;
    tick();
    chk("F reset", pk(out_f, rise_f, fall_f, ch_f), 32'h0);
    rst_f = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk($sformatf("F post k%0d", k), pk(out_f, rise_f, fall_f, ch_f),
          pk(k >= 6, k == 6, 1'b0, k == 6));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
